// File: rtl/lenet_frame_reader.sv
// LeNet input-buffer reader: streams one 28x28 frame per data_ready
// over valid/ready, with sof/eol/eof markers riding along each pixel.
module lenet_frame_reader #(
  parameter int lenet_size = 28,
  parameter int PAD        = 2,
  parameter int ROW_STRIDE = 32,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              data_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              busy,
  output logic              overrun
);

  localparam int CW   = $clog2(lenet_size);
  localparam int LAST = lenet_size - 1;
  localparam int BASE = PAD * ROW_STRIDE + PAD;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state;
  logic [CW-1:0]     x;
  logic [CW-1:0]     y;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_v;
  logic              rd_sof;
  logic              rd_eol;
  logic              rd_eof;
  logic [DATA_W+2:0] fifo [2];
  logic              wp;
  logic              rp;
  logic [1:0]        cnt;
  logic              pop;
  logic [2:0]        occ;
  logic [31:0]       addr_full;
  logic              last_x;
  logic              last_y;

  // Read gating: words held plus in flight, net of this cycle's pop.
  always_comb begin
    pop       = m_valid & m_ready;
    occ       = {1'b0, cnt} + {2'b0, rd_v} - {2'b0, pop};
    rd_en     = (state == READ) && (occ < 3'd2);
    addr_full = BASE + 32'(x) + ROW_STRIDE * 32'(y);
    rd_addr   = rd_en ? addr_full[ADDR_W-1:0] : addr_q;
    last_x    = (x == CW'(LAST));
    last_y    = (y == CW'(LAST));
  end

  assign m_valid = (cnt != 2'd0);
  assign {m_eof, m_eol, m_sof, m_data} = fifo[rp];

  // Frame sequencer: raster address walk, busy and overrun flags.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      addr_q  <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      unique case (state)
        IDLE: begin
          if (data_ready) begin
            state <= READ;
            busy  <= 1'b1;
            x     <= '0;
            y     <= '0;
          end
        end
        READ: begin
          overrun <= data_ready;
          if (rd_en) begin
            addr_q <= rd_addr;
            if (last_x) begin
              x <= '0;
              if (last_y) state <= DRAIN;
              else y <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        DRAIN: begin
          overrun <= data_ready;
          if (pop && m_eof) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Markers follow the read through the one-cycle buffer latency.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      rd_v   <= 1'b0;
      rd_sof <= 1'b0;
      rd_eol <= 1'b0;
      rd_eof <= 1'b0;
    end else begin
      rd_v   <= rd_en;
      rd_sof <= rd_en && (x == '0) && (y == '0);
      rd_eol <= rd_en && last_x;
      rd_eof <= rd_en && last_x && last_y;
    end
  end

  // Two-entry output FIFO holding pixel plus markers.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      cnt     <= 2'd0;
    end else begin
      if (rd_v) begin
        fifo[wp] <= {rd_eof, rd_eol, rd_sof, rd_data};
        wp       <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, rd_v} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_lenet_frame_reader.sv
// Bench for lenet_frame_reader: buffer model, raster reference,
// random backpressure, overrun, mid-frame reset, back-to-back.
module tb_lenet_frame_reader;

  localparam int N    = 28;
  localparam int NPIX = N * N;

  logic       clk25 = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_ready = 1'b0;
  logic       m_ready = 1'b1;
  logic       rd_en;
  logic [9:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_sof;
  logic       m_eol;
  logic       m_eof;
  logic       busy;
  logic       overrun;

  lenet_frame_reader dut (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .data_ready (data_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_sof      (m_sof),
    .m_eol      (m_eol),
    .m_eof      (m_eof),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #20 clk25 = ~clk25;

  int cyc = 0;
  always @(posedge clk25) cyc <= cyc + 1;

  logic [7:0] mem [1024];
  logic [7:0] pix [N][N];

  always @(posedge clk25) if (rd_en) rd_data <= mem[rd_addr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_addr(input int i);
    return 2 * 32 + 2 + (i % N) + 32 * (i / N);
  endfunction

  task automatic fill(input int mode);
    for (int a = 0; a < 1024; a++) mem[a] = 8'hEE;
    for (int yy = 0; yy < N; yy++)
      for (int xx = 0; xx < N; xx++) begin
        pix[yy][xx] = (mode == 0) ? 8'(xx + yy) : 8'($urandom);
        mem[exp_addr(yy * N + xx)] = pix[yy][xx];
      end
  endtask

  logic [24:0] outs;
  logic [10:0] bundle;
  assign outs = {rd_en, rd_addr, m_valid, m_data, m_sof,
                 m_eol, m_eof, busy, overrun};
  assign bundle = {m_eof, m_eol, m_sof, m_data};

  // reference monitor
  bit          active = 0;
  bit          prev_stall = 0;
  logic [10:0] prev_b = '0;
  int          t0 = 0;
  int          pix_idx = 0;
  int          rd_tot = 0;
  int          frames_done = 0;
  int          eof_cnt = 0;
  int          first_cyc = 0;
  int          eof_cyc = 0;

  always @(negedge clk25) begin
    logic [10:0] expb;
    int xx;
    int yy;
    if (!rst_n) begin
      active     = 0;
      prev_stall = 0;
    end else begin
      if (data_ready && !busy) begin
        active  = 1;
        t0      = cyc;
        pix_idx = 0;
        rd_tot  = 0;
      end
      if (prev_stall) check("hold", {m_valid, bundle}, {1'b1, prev_b});
      if (rd_en) begin
        check("addr", rd_addr, exp_addr(rd_tot));
        rd_tot++;
      end
      if (m_valid && m_ready) begin
        check("stray", active, 1);
        if (active) begin
          xx   = pix_idx % N;
          yy   = pix_idx / N;
          expb = {pix_idx == NPIX - 1, xx == N - 1, pix_idx == 0,
                  pix[yy][xx]};
          check("pix", bundle, expb);
          if (pix_idx == 0) first_cyc = cyc;
          pix_idx++;
          if (pix_idx == NPIX) begin
            frames_done++;
            eof_cyc = cyc;
            active  = 0;
          end
        end
        if (m_eof) eof_cnt++;
      end
      if (active) check("outst", (rd_tot - pix_idx) <= 2, 1);
      prev_stall = m_valid && !m_ready;
      prev_b     = bundle;
    end
  end

  // downstream ready pattern
  int rmode = 0;
  int stretch_left = 0;
  bit stretch_done = 0;

  initial forever begin
    @(posedge clk25);
    #1;
    if (rmode == 0) begin
      m_ready = 1'b1;
    end else if (stretch_left > 0) begin
      m_ready = 1'b0;
      stretch_left--;
    end else if (!stretch_done && active && pix_idx >= 13 * N + 3) begin
      stretch_done = 1;
      stretch_left = 19;
      m_ready      = 1'b0;
    end else begin
      m_ready = ($urandom_range(0, 99) < 30);
    end
  end

  bit busy_at_pulse = 0;

  task automatic nstep();
    @(negedge clk25);
    #1;
  endtask

  task automatic pulse_at(input int t);
    while (cyc < t - 1) nstep();
    @(posedge clk25);
    #1 data_ready = 1'b1;
    @(negedge clk25);
    #1 busy_at_pulse = busy;
    @(posedge clk25);
    #1 data_ready = 1'b0;
  endtask

  task automatic start_frame(input int t);
    pulse_at(t);
    check("busy_pre", busy_at_pulse, 0);
    nstep();
    check("t1", {busy, rd_en, rd_addr, overrun}, {2'b11, 10'd66, 1'b0});
    nstep();
    check("t2_valid", m_valid, 0);
    nstep();
    check("t3_sof", {m_valid, m_sof}, 2'b11);
  endtask

  task automatic wait_done(input int limit);
    int s = frames_done;
    int n = 0;
    while (frames_done == s && n < limit) begin
      nstep();
      n++;
    end
    check("done", frames_done - s, 1);
  endtask

  int t;
  int e0;

  initial begin
    fill(0);
    #5 check("rst_out", outs, 0);
    repeat (3) @(posedge clk25);
    #1 rst_n = 1'b1;

    // basic frame, full throughput
    t = cyc + 2;
    start_frame(t);
    wait_done(2000);
    check("eof_cyc", eof_cyc - t, 786);
    check("first_cyc", first_cyc - t, 3);
    check("npix", pix_idx, NPIX);
    check("nread", rd_tot, NPIX);
    check("busy786", busy, 1);

    // back-to-back: pulse in the cycle busy falls
    fill(1);
    t = t + 787;
    start_frame(t);
    wait_done(2000);
    check("b2b_first", first_cyc - t, 3);
    check("b2b_npix", pix_idx, NPIX);

    // overrun at T+100
    fill(1);
    e0 = eof_cnt;
    t  = cyc + 2;
    start_frame(t);
    pulse_at(t + 100);
    nstep();
    check("ovr101", {overrun, busy}, 2'b11);
    nstep();
    check("ovr102", overrun, 0);
    wait_done(2000);
    check("ovr_eofcyc", eof_cyc - t, 786);
    repeat (4) nstep();
    check("ovr_eofs", eof_cnt - e0, 1);

    // backpressure
    rmode = 1;
    stretch_done = 0;
    fill(1);
    start_frame(cyc + 2);
    wait_done(8000);
    check("bp_npix", pix_idx, NPIX);
    check("bp_stretch", stretch_done, 1);
    rmode = 0;
    repeat (3) nstep();

    // reset mid-frame
    fill(1);
    t = cyc + 2;
    start_frame(t);
    e0 = eof_cnt;
    while (cyc < t + 399) nstep();
    @(posedge clk25);
    #1 rst_n = 1'b0;
    #1 check("rst_mid", outs, 0);
    repeat (3) @(posedge clk25);
    #1 rst_n = 1'b1;
    repeat (5) nstep();
    check("rst_noeof", eof_cnt, e0);
    check("rst_idle", {busy, m_valid, rd_en}, 0);
    fill(1);
    start_frame(cyc + 2);
    wait_done(2000);
    check("rst_npix", pix_idx, NPIX);
    check("rst_eofs", eof_cnt - e0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lenet_frame_reader.md
# lenet_frame_reader

Consumer end of the LeNet input buffer. The capture core fills this buffer with a 28×28 downsampled frame and pulses `data_ready`. This block then reads the frame back from the buffer's read port and streams it in raster order to the CNN input over a valid/ready interface. Frame markers are attached, and each frame is read exactly once.

## Interface
Parameters:
- `lenet_size`, 28: pixels per row and rows per frame.
- `PAD`, 2: border offset in the buffer, in both rows and columns.
- `ROW_STRIDE`, 32: buffer words per stored row.
- `ADDR_W`, 10: buffer address width.
- `DATA_W`, 8: pixel width.

Ports:
- `clk25`  in  1  system clock, 25 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `data_ready`  in  1  one-cycle pulse from the capture core; the frame is complete in the buffer.
- `rd_en`  out  1  buffer read strobe.
- `rd_addr`  out  ADDR_W  buffer read address.
- `rd_data`  in  DATA_W  buffer read data, valid one cycle after `rd_en`.
- `m_valid`  out  1  output pixel valid.
- `m_ready`  in  1  downstream accepts the pixel.
- `m_data`  out  DATA_W  pixel value.
- `m_sof`  out  1  first pixel of the frame.
- `m_eol`  out  1  last pixel of a row.
- `m_eof`  out  1  last pixel of the frame.
- `busy`  out  1  a frame is in progress.
- `overrun`  out  1  one-cycle pulse; a `data_ready` arrived while busy.

## Operation
- Pixel (x,y) is stored at address `PAD*ROW_STRIDE + PAD + x + ROW_STRIDE*y`. With the defaults, the first address is 66 and the last is 66+27+32·27 = 957.
- The FSM has three states:
  - IDLE: waits for `data_ready`, then goes to READ.
  - READ: issues reads for x = 0..27 in the inner loop and y = 0..27 in the outer loop. After the 784th read it goes to DRAIN.
  - DRAIN: waits until all issued pixels have been accepted, then returns to IDLE.
- Buffering:
  - Read data lands in a 2-entry output FIFO.
  - `rd_en` is asserted only when the FIFO occupancy plus the read in flight is below 2, counting a pop in the same cycle.
  - No pixel may be dropped or duplicated, under any `m_ready` pattern.
- Output handshake:
  - A transfer happens when `m_valid` and `m_ready` are both high.
  - While `m_valid` is high and `m_ready` is low, `m_data`, `m_sof`, `m_eol` and `m_eof` are held stable.
  - `m_valid` never drops without a transfer.
- Markers travel with their pixel through the FIFO:
  - `m_sof` at (0,0).
  - `m_eol` at x = 27.
  - `m_eof` at (27,27); this pixel also has `m_eol` high.
- `busy` is high from the cycle after `data_ready` is accepted until the cycle after the `m_eof` transfer.
- A `data_ready` while `busy` is ignored and produces `overrun` = 1 for one cycle. The current frame is unaffected.
- Address arithmetic uses the counters x and y, each `$clog2(lenet_size)` bits wide. The address is computed at full width and truncated to ADDR_W bits.

## Timing
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE and the FIFO empties.
  - `rd_en`, `rd_addr`, `m_valid`, `m_data`, `m_sof`, `m_eol`, `m_eof`, `busy` and `overrun` are all 0.
  - A partial frame is discarded, and no `m_eof` is emitted for it.
- Latency: `data_ready` high in cycle T gives:
  - `busy` = 1 and `rd_en` = 1 with `rd_addr` = 66 in T+1.
  - `rd_data` valid in T+2.
  - `m_valid` = 1 with `m_sof` = 1 in T+3.
- Throughput: with `m_ready` held high, one pixel is transferred per cycle with no bubbles.
  - Last transfer (`m_eof`) in T+786.
  - `busy` = 0 in T+787.
- Back-to-back frames: a `data_ready` in the same cycle that `busy` falls is accepted. A `data_ready` in the `m_eof` transfer cycle itself is an overrun.
- `rd_addr` holds its last value when `rd_en` = 0. The buffer's read port is always enabled, so there is no read-during-write ordering requirement on this side.

## Test plan
- **Basic frame:** preload the buffer with pixel(x,y) = (x+y) & 0xFF, pulse `data_ready`, hold `m_ready` = 1.
  - Expect 784 transfers in T+3..T+786.
  - Data is x+y in raster order.
  - `m_sof` appears only on the first transfer, `m_eol` on every 28th transfer, `m_eof` only on the 784th.
  - `busy` falls at T+787.
- **Address check:** monitor `rd_en`/`rd_addr`.
  - Expect exactly 784 reads: 66..93, 98..125, …, 930..957, strictly increasing.
  - No read of a pad address, e.g. 94 or 0.
- **Backpressure:** drive `m_ready` with a random 30% duty, plus a 20-cycle low stretch in row 13.
  - Expect no loss or duplication and held data while stalled.
  - Never more than 2 reads outstanding beyond the accepted pixels.
- **Overrun:** pulse `data_ready` again at T+100.
  - Expect `overrun` = 1 at T+101 only.
  - Frame output identical to the basic case.
  - A single `m_eof`.
- **Reset mid-frame:** assert `rst_n` = 0 at T+400 for 3 cycles.
  - All outputs go to 0 immediately.
  - After release and a new `data_ready`, a complete frame is output starting with `m_sof` at pixel (0,0).
- **Back-to-back:** pulse `data_ready` in the cycle `busy` falls.
  - Second frame accepted with no overrun.
  - `m_sof` 3 cycles later.
